// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus debounce FSM: turns a raw, possibly bouncing switch level
// into a clean level, one-cycle rise/fall pulses and a wrapping count of accepted rises.
//
//   state     | meaning
//   ----------+---------------------------------------------------------------
//   IDLE_LOW  | clean level is 0, waiting for sync2 to go high
//   WAIT_HIGH | sync2 high, qualifying; cnt counts stable cycles before accept
//   IDLE_HIGH | clean level is 1, waiting for sync2 to go low
//   WAIT_LOW  | sync2 low, qualifying; cnt counts stable cycles before accept
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   switch,
    input  logic                   count_clear,
    output logic                   switch_clean,
    output logic                   rise_pulse,
    output logic                   fall_pulse,
    output logic [COUNT_WIDTH-1:0] toggle_count
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             sync1;
    logic             sync2;
    logic             clean_next;
    logic             rise_next;
    logic             fall_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= switch;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE_LOW;
            cnt          <= '0;
            switch_clean <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            switch_clean <= clean_next;
            rise_pulse   <= rise_next;
            fall_pulse   <= fall_next;
        end
    end

    // Any abort drops cnt back to zero so qualification never resumes mid-count.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clean_next = switch_clean;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            IDLE_LOW: begin
                cnt_next = '0;
                if (sync2) state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                    clean_next = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                cnt_next = '0;
                if (!sync2) state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                    clean_next = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // Clear takes priority over a coincident rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            toggle_count <= '0;
        end else if (count_clear) begin
            toggle_count <= '0;
        end else if (rise_next) begin
            toggle_count <= toggle_count + COUNT_WIDTH'(1);
        end
    end

endmodule
